// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: opcodes, fetch-queue entry layout and FSM states.
package rv_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned FQ_ENTRY_W = 98;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic            is_c;
      logic            pred_taken;
      logic [XLEN-1:0] pred_pc;
   } fq_entry_t;

   function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] i);
      return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] i);
      return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO for fetched instructions; head entry and valid are registered.
module fetch_queue #(
   parameter int unsigned W  = 98,
   parameter int unsigned AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   input  logic          clear,
   output logic [AW:0]   count,
   output logic          out_valid,
   output logic [W-1:0]  out_data
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [W-1:0]  head_q, head_d;
   logic          valid_q, valid_d;

   // Next pointers/storage; head is looked up from next-state so it is a flop output.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
      head_d  = mem_d[rd_ptr_d];
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
      end
   end

   assign count     = count_q;
   assign out_valid = valid_q;
   assign out_data  = head_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the fetch PC, issues one icache request at a time,
// predicts the next PC statically and queues results for decode.
module ifetch
   import rv_pkg::*;
#(
   parameter logic [31:0]  RESET_PC    = 32'h0000_0000,
   parameter int unsigned  QUEUE_WIDTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        have_result,
   input  logic [31:0] inst,
   output logic        to_icache,
   output logic [31:0] pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        out_is_c,
   output logic        out_pred_taken,
   output logic [31:0] out_pred_pc
);

   localparam int unsigned DEPTH = 1 << QUEUE_WIDTH;
   localparam int unsigned CW    = QUEUE_WIDTH + 1;

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pending_pc_q, pending_pc_d;
   logic         to_icache_q, to_icache_d;

   logic                  fq_push, fq_pop, fq_clear, fq_valid;
   logic [CW-1:0]         fq_count;
   logic [FQ_ENTRY_W-1:0] head_bits;
   fq_entry_t             push_entry, head_entry;

   logic        is_c, is_jal, is_bwd_br, pred_taken;
   logic [31:0] next_pc;

   // Static prediction: JAL and backward branches taken, all else falls through.
   always_comb begin
      is_c       = (inst[1:0] != 2'b11);
      is_jal     = !is_c && (inst[6:0] == OP_JAL);
      is_bwd_br  = !is_c && (inst[6:0] == OP_BRANCH) && inst[31];
      pred_taken = is_jal || is_bwd_br;
      if (is_jal)         next_pc = pc_q + imm_j(inst);
      else if (is_bwd_br) next_pc = pc_q + imm_b(inst);
      else                next_pc = pc_q + (is_c ? 32'd2 : 32'd4);
   end

   assign push_entry = '{inst: inst, pc: pc_q, is_c: is_c,
                         pred_taken: pred_taken, pred_pc: next_pc};

   // A pop in a flush cycle is not consumed: the queue is cleared anyway.
   assign fq_pop = rdy && fq_valid && out_ready && !flush;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_pc_d = pending_pc_q;
      to_icache_d  = to_icache_q;
      fq_push      = 1'b0;
      fq_clear     = 1'b0;
      if (rdy) begin
         to_icache_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (flush) begin
                  pc_d     = flush_pc;
                  fq_clear = 1'b1;
               end else if ((fq_count - CW'(fq_pop)) < CW'(DEPTH)) begin
                  to_icache_d = 1'b1;
                  state_d     = S_WAIT;
               end
            end
            S_WAIT: begin
               if (flush) begin
                  fq_clear = 1'b1;
                  if (have_result) begin
                     pc_d        = flush_pc;
                     to_icache_d = 1'b1;
                  end else begin
                     pending_pc_d = flush_pc;
                     state_d      = S_DISCARD;
                  end
               end else if (have_result) begin
                  fq_push = 1'b1;
                  pc_d    = next_pc;
                  if ((fq_count + CW'(1) - CW'(fq_pop)) < CW'(DEPTH)) begin
                     to_icache_d = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_DISCARD: begin
               if (flush) begin
                  fq_clear     = 1'b1;
                  pending_pc_d = flush_pc;
               end
               if (have_result) begin
                  pc_d        = flush ? flush_pc : pending_pc_q;
                  to_icache_d = 1'b1;
                  state_d     = S_WAIT;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         pending_pc_q <= '0;
         to_icache_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_pc_q <= pending_pc_d;
         to_icache_q  <= to_icache_d;
      end
   end

   fetch_queue #(
      .W  (FQ_ENTRY_W),
      .AW (QUEUE_WIDTH)
   ) u_fetch_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (fq_push),
      .push_data (push_entry),
      .pop       (fq_pop),
      .clear     (fq_clear),
      .count     (fq_count),
      .out_valid (fq_valid),
      .out_data  (head_bits)
   );

   assign head_entry     = fq_entry_t'(head_bits);
   assign to_icache      = to_icache_q;
   assign pc             = pc_q;
   assign out_valid      = fq_valid;
   assign out_inst       = head_entry.inst;
   assign out_pc         = head_entry.pc;
   assign out_is_c       = head_entry.is_c;
   assign out_pred_taken = head_entry.pred_taken;
   assign out_pred_pc    = head_entry.pred_pc;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a simple latency-programmable icache model.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst, rdy, flush, have_result, out_ready;
   logic [31:0] flush_pc, inst;
   logic        to_icache, out_valid, out_is_c, out_pred_taken;
   logic [31:0] pc, out_inst, out_pc, out_pred_pc;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int lat    = 1;
   int pend   = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] req_pc  [$];
   int          req_cyc [$];
   logic [31:0] cap_pc  [$];
   logic [31:0] cap_ppc [$];
   logic        cap_c   [$];
   logic        cap_tk  [$];

   always #5 clk = ~clk;

   ifetch dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .flush          (flush),
      .flush_pc       (flush_pc),
      .have_result    (have_result),
      .inst           (inst),
      .to_icache      (to_icache),
      .pc             (pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_is_c       (out_is_c),
      .out_pred_taken (out_pred_taken),
      .out_pred_pc    (out_pred_pc)
   );

   function automatic logic [31:0] imem(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0000_0013;
   endfunction

   function automatic logic [31:0] get32(input logic [31:0] q [$], input int i);
      if (i < q.size()) return q[i];
      return 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] get1(input logic q [$], input int i);
      if (i < q.size()) return {31'b0, q[i]};
      return 32'hxxxx_xxxx;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      req_pc.delete(); req_cyc.delete();
      cap_pc.delete(); cap_ppc.delete(); cap_c.delete(); cap_tk.delete();
   endtask

   // One clock: log decoder pops, then advance the icache model after the edge.
   task automatic tick();
      if (rdy && out_valid && out_ready && !flush) begin
         cap_pc.push_back(out_pc);
         cap_ppc.push_back(out_pred_pc);
         cap_c.push_back(out_is_c);
         cap_tk.push_back(out_pred_taken);
      end
      @(posedge clk); #1;
      cyc++;
      have_result = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            have_result = 1'b1;
            inst        = imem(pc);
         end
      end
      if (to_icache && rdy) begin
         req_pc.push_back(pc);
         req_cyc.push_back(cyc);
         pend = lat;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; have_result = 1'b0; pend = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic redirect(input logic [31:0] a);
      clear_logs();
      flush = 1'b1; flush_pc = a;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = '0;
      have_result = 1'b0; inst = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_to_icache", {31'b0, to_icache}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      rst = 1'b0;

      // Sequential hits: strobe every 2 cycles, in-order output.
      repeat (10) tick();
      chk("seq_req0", get32(req_pc, 0), 32'h0);
      chk("seq_req1", get32(req_pc, 1), 32'h4);
      chk("seq_req2", get32(req_pc, 2), 32'h8);
      chk("seq_gap01", 32'(req_cyc[1] - req_cyc[0]), 32'd2);
      chk("seq_gap12", 32'(req_cyc[2] - req_cyc[1]), 32'd2);
      chk("seq_out0", get32(cap_pc, 0), 32'h0);
      chk("seq_out1", get32(cap_pc, 1), 32'h4);
      chk("seq_out2", get32(cap_pc, 2), 32'h8);
      chk("seq_is_c", get1(cap_c, 0), 32'd0);
      chk("seq_ppc1", get32(cap_ppc, 1), 32'h8);

      // Compressed instruction advances by 2.
      mem[32'h0] = 32'h0000_0001;
      do_reset();
      repeat (10) tick();
      chk("c_is_c", get1(cap_c, 0), 32'd1);
      chk("c_taken", get1(cap_tk, 0), 32'd0);
      chk("c_ppc", get32(cap_ppc, 0), 32'h2);
      chk("c_req1", get32(req_pc, 1), 32'h2);
      chk("c_out1", get32(cap_pc, 1), 32'h2);
      chk("c_ppc1", get32(cap_ppc, 1), 32'h6);
      mem.delete(32'h0);

      // JAL forward and backward branch are predicted taken.
      mem[32'h10] = 32'h0100_006F;
      mem[32'h20] = 32'hFE00_0CE3;
      redirect(32'h10);
      repeat (14) tick();
      chk("jal_pc", get32(cap_pc, 0), 32'h10);
      chk("jal_tk", get1(cap_tk, 0), 32'd1);
      chk("jal_ppc", get32(cap_ppc, 0), 32'h20);
      chk("jal_req", get32(req_pc, 1), 32'h20);
      chk("bwd_pc", get32(cap_pc, 1), 32'h20);
      chk("bwd_tk", get1(cap_tk, 1), 32'd1);
      chk("bwd_ppc", get32(cap_ppc, 1), 32'h18);
      chk("bwd_req", get32(req_pc, 2), 32'h18);
      chk("bwd_out2", get32(cap_pc, 2), 32'h18);

      // Forward branch and JALR fall through.
      mem[32'h40] = 32'h0000_0463;
      mem[32'h44] = 32'h0000_8067;
      redirect(32'h40);
      repeat (12) tick();
      chk("fwd_pc", get32(cap_pc, 0), 32'h40);
      chk("fwd_tk", get1(cap_tk, 0), 32'd0);
      chk("fwd_ppc", get32(cap_ppc, 0), 32'h44);
      chk("jalr_tk", get1(cap_tk, 1), 32'd0);
      chk("jalr_ppc", get32(cap_ppc, 1), 32'h48);

      // Miss with a flush while the request is outstanding.
      lat = 11;
      do_reset();
      repeat (3) tick();
      flush = 1'b1; flush_pc = 32'h100;
      tick();
      flush = 1'b0;
      lat = 1;
      chk("miss_pc_after_flush", pc, 32'h0);
      chk("miss_valid_after_flush", {31'b0, out_valid}, 32'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (req_pc.size() > 1) break;
         chk("miss_pc_hold", pc, 32'h0);
      end
      chk("miss_req_new", get32(req_pc, 1), 32'h100);
      chk("miss_dropped", {31'b0, out_valid}, 32'd0);
      repeat (6) tick();
      chk("miss_first_out", get32(cap_pc, 0), 32'h100);

      // Back-pressure: four entries then silence.
      do_reset();
      out_ready = 1'b0;
      repeat (12) tick();
      chk("full_reqs", 32'(req_pc.size()), 32'd4);
      chk("full_req3", get32(req_pc, 3), 32'hC);
      chk("full_to_icache", {31'b0, to_icache}, 32'd0);
      chk("full_valid", {31'b0, out_valid}, 32'd1);
      chk("full_head", out_pc, 32'h0);

      // Paused: flush and pop are both ignored.
      rdy = 1'b0; out_ready = 1'b1; flush = 1'b1; flush_pc = 32'h300;
      repeat (2) tick();
      chk("rdy_valid", {31'b0, out_valid}, 32'd1);
      chk("rdy_head", out_pc, 32'h0);
      chk("rdy_pc", pc, 32'h10);
      chk("rdy_to_icache", {31'b0, to_icache}, 32'd0);
      rdy = 1'b1; flush = 1'b0;

      clear_logs();
      repeat (14) tick();
      chk("drain0", get32(cap_pc, 0), 32'h0);
      chk("drain1", get32(cap_pc, 1), 32'h4);
      chk("drain2", get32(cap_pc, 2), 32'h8);
      chk("drain3", get32(cap_pc, 3), 32'hC);
      chk("drain4", get32(cap_pc, 4), 32'h10);
      chk("resume_req", get32(req_pc, 0), 32'h10);

      // Flush concurrent with a pop on a full queue.
      out_ready = 1'b0;
      repeat (14) tick();
      chk("refill_valid", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1;
      redirect(32'h200);
      out_ready = 1'b0;
      chk("flushpop_valid", {31'b0, out_valid}, 32'd0);
      chk("flushpop_pc", pc, 32'h200);
      tick();
      chk("flushpop_req", get32(req_pc, 0), 32'h200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
